// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin shared adder with a single registered result slot
module adder_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int HAS_CIN = 0,
  parameter int N_REQ   = 4,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_cin,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH:0]         res_sum,
  output logic [ID_W-1:0]        res_id
);

  typedef enum logic {EMPTY, FULL} slot_state_e;

  slot_state_e     state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WIDTH:0]  res_sum_q, res_sum_d;
  logic [ID_W-1:0] res_id_q, res_id_d;

  logic            found;
  logic [ID_W-1:0] grant;
  logic            can_accept;
  logic            accept;
  logic [WIDTH-1:0] a_g, b_g;
  logic            cin_g;
  logic [WIDTH:0]  sum_g;
  int              idx;

  // Rotating-priority search starting at rr_ptr_q, first valid requester wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        grant = idx[ID_W-1:0];
      end
    end
  end

  assign can_accept = (state_q == EMPTY) || res_ready;
  assign accept     = found && can_accept && !rst;
  assign req_ready  = accept ? (N_REQ'(1) << grant) : '0;

  assign a_g   = req_a[grant*WIDTH +: WIDTH];
  assign b_g   = req_b[grant*WIDTH +: WIDTH];
  assign cin_g = (HAS_CIN != 0) ? req_cin[grant] : 1'b0;
  assign sum_g = {1'b0, a_g} + {1'b0, b_g} + {{WIDTH{1'b0}}, cin_g};

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    res_sum_d = res_sum_q;
    res_id_d  = res_id_q;
    if (accept) begin
      // Covers both EMPTY->FULL and FULL->FULL with simultaneous pop.
      state_d   = FULL;
      res_sum_d = sum_g;
      res_id_d  = grant;
      rr_ptr_d  = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
    end else if (state_q == FULL && res_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      rr_ptr_q  <= '0;
      res_sum_q <= '0;
      res_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      res_sum_q <= res_sum_d;
      res_id_q  <= res_id_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - directed self-checking bench for adder_share_arbiter
module tb_adder_share_arbiter;

  localparam int WIDTH = 32;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_cin;
  logic                   res_ready;

  logic [N_REQ-1:0] req_ready, req_ready_c;
  logic             res_valid, res_valid_c;
  logic [WIDTH:0]   res_sum, res_sum_c;
  logic [ID_W-1:0]  res_id, res_id_c;

  int n_checks = 0;
  int n_errors = 0;

  adder_share_arbiter #(.WIDTH(WIDTH), .HAS_CIN(0), .N_REQ(N_REQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_id(res_id)
  );

  adder_share_arbiter #(.WIDTH(WIDTH), .HAS_CIN(1), .N_REQ(N_REQ)) dut_cin (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_c),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .res_valid(res_valid_c), .res_ready(res_ready), .res_sum(res_sum_c), .res_id(res_id_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    res_ready = 1'b0;
    req_cin   = 4'b0000;
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
      req_b[i*WIDTH +: WIDTH] = 32'd100;
    end

    // Reset with all requesters valid
    tick();
    chk("rst1_req_ready", 64'(req_ready), 64'h0);
    chk("rst1_res_valid", 64'(res_valid), 64'h0);
    chk("rst1_res_sum",   64'(res_sum),   64'h0);
    chk("rst1_res_id",    64'(res_id),    64'h0);
    tick();
    chk("rst2_req_ready", 64'(req_ready), 64'h0);
    chk("rst2_res_valid", 64'(res_valid), 64'h0);

    // Round robin, all valid, consumer always ready
    rst       = 1'b0;
    res_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rr%0d_req_ready", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("rr%0d_res_valid", k), 64'(res_valid), 64'h1);
      chk($sformatf("rr%0d_res_id", k),    64'(res_id),    64'(k % 4));
      chk($sformatf("rr%0d_res_sum", k),   64'(res_sum),   64'((k % 4) + 101));
    end

    req_valid = 4'b0000;
    #1;
    chk("drain_req_ready", 64'(req_ready), 64'h0);
    tick();
    chk("drain_res_valid", 64'(res_valid), 64'h0);

    // Single requester with carry-out
    req_a[2*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
    req_b[2*WIDTH +: WIDTH] = 32'h0000_0001;
    req_valid = 4'b0100;
    #1;
    chk("single_req_ready", 64'(req_ready), 64'h4);
    tick();
    chk("single_res_valid", 64'(res_valid), 64'h1);
    chk("single_res_sum",   64'(res_sum),   64'h1_0000_0000);
    chk("single_res_id",    64'(res_id),    64'h2);
    chk("single_sum_cin",   64'(res_sum_c), 64'h1_0000_0000);

    // Pointer now 3: all valid picks 3; only 1 valid wraps to 1
    req_valid = 4'b1111;
    #1;
    chk("ptr3_req_ready", 64'(req_ready), 64'h8);
    req_valid = 4'b0010;
    #1;
    chk("wrap_req_ready", 64'(req_ready), 64'h2);
    tick();
    chk("wrap_res_id",  64'(res_id),  64'h1);
    chk("wrap_res_sum", 64'(res_sum), 64'd102);

    // Backpressure with requester 3 waiting
    res_ready = 1'b0;
    req_valid = 4'b1000;
    req_a[3*WIDTH +: WIDTH] = 32'd5;
    req_b[3*WIDTH +: WIDTH] = 32'd7;
    req_cin   = 4'b1000;
    #1;
    chk("bp_req_ready0", 64'(req_ready), 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp%0d_res_valid", k), 64'(res_valid), 64'h1);
      chk($sformatf("bp%0d_res_id", k),    64'(res_id),    64'h1);
      chk($sformatf("bp%0d_res_sum", k),   64'(res_sum),   64'd102);
      chk($sformatf("bp%0d_req_ready", k), 64'(req_ready), 64'h0);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_req_ready", 64'(req_ready), 64'h8);
    tick();
    chk("bp_new_res_valid", 64'(res_valid),  64'h1);
    chk("bp_new_res_id",    64'(res_id),     64'h3);
    chk("cin0_res_sum",     64'(res_sum),    64'd12);
    chk("cin1_res_sum",     64'(res_sum_c),  64'd13);
    chk("cin1_res_id",      64'(res_id_c),   64'h3);

    // Reset while a result is held
    req_cin   = 4'b0000;
    req_valid = 4'b0001;
    #1;
    chk("pre_rst_req_ready", 64'(req_ready), 64'h1);
    tick();
    res_ready = 1'b0;
    req_valid = 4'b0000;
    tick();
    chk("held_res_valid", 64'(res_valid), 64'h1);
    chk("held_res_sum",   64'(res_sum),   64'd101);
    rst       = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("midrst_req_ready", 64'(req_ready), 64'h0);
    tick();
    chk("midrst_res_valid", 64'(res_valid), 64'h0);
    chk("midrst_res_sum",   64'(res_sum),   64'h0);
    chk("midrst_res_id",    64'(res_id),    64'h0);
    rst       = 1'b0;
    res_ready = 1'b1;
    #1;
    chk("midrst_ptr_req_ready", 64'(req_ready), 64'h1);
    req_valid = 4'b0000;
    tick();
    chk("midrst_no_delivery", 64'(res_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one WIDTH-bit adder datapath among N_REQ requesters using round-robin arbitration.
- Each requester presents operands with a valid/ready handshake.
- The granted operation's sum is registered into a single output slot, tagged with the requester ID, and held under backpressure.
- Sits between multiple compute clients and the single adder instance, so the area cost is one adder plus one result register.

Parameters:
- WIDTH, 32, operand width in bits; sum is WIDTH+1 bits.
- HAS_CIN, 0, when 1 the per-requester carry-in is added; when 0 carry-in inputs are ignored (treated as 0).
- N_REQ, 4, number of requesters; legal range 2..16.
- ID_W (localparam), clog2(N_REQ), width of the requester ID tag.

Ports:
- clk  input  1  single clock, all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  bit i: requester i has an operation pending.
- req_ready  output  N_REQ  bit i: requester i's operation is accepted this cycle; one-hot or zero.
- req_a  input  N_REQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  N_REQ*WIDTH  operand b, same packing as req_a.
- req_cin  input  N_REQ  per-requester carry-in; used only when HAS_CIN=1.
- res_valid  output  1  result slot holds a valid sum.
- res_ready  input  1  consumer accepts the result this cycle.
- res_sum  output  WIDTH+1  registered a+b(+cin), zero-extended, carry-out in the MSB.
- res_id  output  ID_W  index of the requester that produced res_sum.

Behaviour:
- Reset (rst=1 at a clock edge) gives the following; reset mid-operation discards any held result, no partial state survives:
  - res_valid=0, res_sum=0, res_id=0.
  - Round-robin pointer rr_ptr=0.
  - FSM=EMPTY.
  - req_ready=0 during the reset cycle.
- Output slot FSM, two states:
  - EMPTY: slot free; can_accept=1.
  - FULL: slot holds a result; can_accept=res_ready, so a pop and a new accept may occur in the same cycle.
  - EMPTY->FULL on an accept.
  - FULL->EMPTY on res_ready with no accept.
  - FULL->FULL when res_ready=0 (result held stable), or when res_ready=1 together with an accept (slot replaced by the new result).
- Arbitration, combinational in the cycle:
  - Search req_valid starting at index rr_ptr, ascending with wrap-around modulo N_REQ.
  - The first set bit is the grant g.
  - req_ready[g]=can_accept; all other req_ready bits are 0.
  - If no bit is set, there is no grant and req_ready=0.
- Accept occurs when req_valid[g] && req_ready[g]. On the clock edge:
  - res_sum <= {1'b0,a_g} + {1'b0,b_g} + (HAS_CIN ? cin_g : 0), with full WIDTH+1 precision and no truncation.
  - res_id <= g.
  - res_valid <= 1.
  - rr_ptr <= (g+1) mod N_REQ.
- rr_ptr changes only on an accept. A stalled grant (can_accept=0) does not rotate priority.
- Latency: accept in cycle T gives res_valid=1 with the result in cycle T+1. Sustained throughput is one result per cycle while res_ready=1.
- Stability:
  - While res_valid=1 && res_ready=0, res_sum and res_id are held unchanged.
  - Requesters must hold req_valid and operands until req_ready; the block does not latch operands before accept.
- Fairness: with all requesters continuously valid and res_ready=1, grants cycle 0,1,...,N_REQ-1,0,... Each requester is served at least once every N_REQ accepts.
- Boundary conditions:
  - Max operands give carry-out in res_sum[WIDTH].
  - A requester dropping req_valid while waiting is allowed; arbitration simply re-evaluates the next cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, res_valid=0, res_sum=0. After release, first grant goes to requester 0.
- Single requester: WIDTH=32, req 2 a=0xFFFFFFFF b=0x1, res_ready=1 -> res_valid=1 next cycle, res_sum=0x1_0000_0000, res_id=2, rr_ptr=3.
- Round-robin: req_valid=4'b1111, res_ready=1 for 8 cycles -> res_id sequence 0,1,2,3,0,1,2,3, one result per cycle.
- Backpressure: result from req 1 present, res_ready=0 for 3 cycles with req 3 valid -> res_sum and res_id stable, req_ready=0, rr_ptr unchanged. Then res_ready=1 -> req 3 accepted the same cycle and its result appears the next cycle.
- Carry-in: HAS_CIN=1, a=5 b=7 cin=1 -> res_sum=13. The same stimulus with HAS_CIN=0 -> res_sum=12.
- Reset mid-operation: res_valid=1 held under backpressure, assert rst -> res_valid=0 next cycle, rr_ptr=0, and the held result is never delivered.
